// File: rtl/snake_engine.sv
// Snake movement, growth and collision engine with a tick timebase, status FSM
// and a registered per-cell query port for the renderer.
module snake_engine #(
  parameter int GRID_W    = 40,
  parameter int GRID_H    = 30,
  parameter int X_W       = 6,
  parameter int Y_W       = 5,
  parameter int MAX_LEN   = 16,
  parameter int INIT_LEN  = 3,
  parameter int TICK_DIV  = 12_500_000,
  parameter int DIE_TICKS = 8,
  parameter int WRAP      = 0
) (
  input  logic                         CLK_50M,
  input  logic                         RSTn,
  input  logic                         start,
  input  logic                         left_press,
  input  logic                         right_press,
  input  logic                         up_press,
  input  logic                         down_press,
  input  logic                         add_cube,
  input  logic [X_W-1:0]               query_x,
  input  logic [Y_W-1:0]               query_y,
  output logic [1:0]                   query_hit,
  output logic [X_W-1:0]               head_x,
  output logic [Y_W-1:0]               head_y,
  output logic [$clog2(MAX_LEN+1)-1:0] cube_num,
  output logic [1:0]                   game_status,
  output logic                         hit_wall,
  output logic                         hit_body,
  output logic                         die_flash,
  output logic                         step
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DIE_W = (DIE_TICKS > 1) ? $clog2(DIE_TICKS) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [DIE_W-1:0] DIE_LAST  = DIE_W'(DIE_TICKS - 1);
  localparam logic [X_W-1:0]   X_MAX     = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX     = Y_W'(GRID_H - 1);
  localparam logic [Y_W-1:0]   HOME_Y    = Y_W'(GRID_H / 2);
  localparam logic [LEN_W-1:0] LEN_INIT  = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_PLAY = 2'b01, ST_DIE = 2'b10} state_t;
  typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_t;

  // Inactive home slots all park on the tail cell so nothing stray shows up later.
  function automatic logic [X_W-1:0] home_x(input int idx);
    if (idx < INIT_LEN) return X_W'(GRID_W / 2 - idx);
    else return X_W'(GRID_W / 2 - INIT_LEN + 1);
  endfunction

  state_t             state_r, state_nxt_s;
  dir_t               cur_dir_r, next_dir_r, dir_sel_s;
  logic [CNT_W-1:0]   tick_cnt_r;
  logic [DIE_W-1:0]   die_cnt_r;
  logic [X_W-1:0]     seg_x_r [MAX_LEN];
  logic [Y_W-1:0]     seg_y_r [MAX_LEN];
  logic [LEN_W-1:0]   cube_num_r;
  logic               grow_pending_r, hit_wall_r, hit_body_r, die_flash_r, step_r;
  logic [1:0]         query_hit_r, query_s;
  logic [X_W-1:0]     cand_x_s;
  logic [Y_W-1:0]     cand_y_s;
  logic               wall_s, body_s, grow_s, tick_s, move_tick_s, move_ok_s, collide_s, die_done_s;

  assign tick_s      = (state_r != ST_IDLE) && (tick_cnt_r == TICK_LAST);
  assign move_tick_s = tick_s && (state_r == ST_PLAY);
  assign grow_s      = grow_pending_r && (cube_num_r < LEN_MAX);
  assign collide_s   = move_tick_s && (wall_s || body_s);
  assign move_ok_s   = move_tick_s && !wall_s && !body_s;
  assign die_done_s  = tick_s && (state_r == ST_DIE) && (die_cnt_r == DIE_LAST);

  // Highest-priority press that does not reverse the applied direction.
  always_comb begin
    dir_sel_s = next_dir_r;
    if (up_press && cur_dir_r != DIR_DOWN) dir_sel_s = DIR_UP;
    else if (down_press && cur_dir_r != DIR_UP) dir_sel_s = DIR_DOWN;
    else if (left_press && cur_dir_r != DIR_RIGHT) dir_sel_s = DIR_LEFT;
    else if (right_press && cur_dir_r != DIR_LEFT) dir_sel_s = DIR_RIGHT;
    else dir_sel_s = next_dir_r;
  end

  always_comb begin
    cand_x_s = seg_x_r[0];
    cand_y_s = seg_y_r[0];
    wall_s   = 1'b0;
    case (next_dir_r)
      DIR_UP: begin
        if (seg_y_r[0] != Y_W'(0)) cand_y_s = seg_y_r[0] - Y_W'(1);
        else if (WRAP != 0) cand_y_s = Y_MAX;
        else wall_s = 1'b1;
      end
      DIR_DOWN: begin
        if (seg_y_r[0] != Y_MAX) cand_y_s = seg_y_r[0] + Y_W'(1);
        else if (WRAP != 0) cand_y_s = Y_W'(0);
        else wall_s = 1'b1;
      end
      DIR_LEFT: begin
        if (seg_x_r[0] != X_W'(0)) cand_x_s = seg_x_r[0] - X_W'(1);
        else if (WRAP != 0) cand_x_s = X_MAX;
        else wall_s = 1'b1;
      end
      DIR_RIGHT: begin
        if (seg_x_r[0] != X_MAX) cand_x_s = seg_x_r[0] + X_W'(1);
        else if (WRAP != 0) cand_x_s = X_W'(0);
        else wall_s = 1'b1;
      end
      default: wall_s = 1'b0;
    endcase
  end

  // The tail cell is vacated by the move unless the snake grows on it.
  always_comb begin
    body_s = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < cube_num_r) && !((LEN_W'(i) == cube_num_r - LEN_W'(1)) && !grow_s) &&
          (seg_x_r[i] == cand_x_s) && (seg_y_r[i] == cand_y_s)) body_s = 1'b1;
      else body_s = body_s;
    end
  end

  always_comb begin
    query_s = 2'b00;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < cube_num_r) && (seg_x_r[i] == query_x) && (seg_y_r[i] == query_y)) query_s = 2'b10;
      else query_s = query_s;
    end
    if ((seg_x_r[0] == query_x) && (seg_y_r[0] == query_y)) query_s = 2'b01;
    else query_s = query_s;
  end

  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: if (start) state_nxt_s = ST_PLAY; else state_nxt_s = ST_IDLE;
      ST_PLAY: if (collide_s) state_nxt_s = ST_DIE; else state_nxt_s = ST_PLAY;
      ST_DIE:  if (die_done_s) state_nxt_s = ST_IDLE; else state_nxt_s = ST_DIE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) state_r <= ST_IDLE;
    else state_r <= state_nxt_s;
  end

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      tick_cnt_r  <= CNT_W'(0);
      die_cnt_r   <= DIE_W'(0);
      die_flash_r <= 1'b0;
    end else begin
      if (state_r == ST_IDLE || tick_s) tick_cnt_r <= CNT_W'(0);
      else tick_cnt_r <= tick_cnt_r + CNT_W'(1);
      if (state_r != ST_DIE || die_done_s) begin
        die_cnt_r   <= DIE_W'(0);
        die_flash_r <= 1'b0;
      end else if (tick_s) begin
        die_cnt_r   <= die_cnt_r + DIE_W'(1);
        die_flash_r <= ~die_flash_r;
      end
    end
  end

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      cur_dir_r <= DIR_RIGHT; next_dir_r <= DIR_RIGHT;
      grow_pending_r <= 1'b0; hit_wall_r <= 1'b0; hit_body_r <= 1'b0;
      step_r <= 1'b0; query_hit_r <= 2'b00;
    end else begin
      step_r      <= move_ok_s;
      query_hit_r <= query_s;
      if (die_done_s) begin
        cur_dir_r <= DIR_RIGHT; next_dir_r <= DIR_RIGHT;
        grow_pending_r <= 1'b0; hit_wall_r <= 1'b0; hit_body_r <= 1'b0;
      end else begin
        if (move_ok_s) cur_dir_r <= next_dir_r;
        if (state_r == ST_PLAY) next_dir_r <= dir_sel_s;
        if (move_tick_s) grow_pending_r <= add_cube;
        else if (state_r == ST_PLAY && add_cube) grow_pending_r <= 1'b1;
        if (collide_s) begin
          hit_wall_r <= wall_s;
          hit_body_r <= body_s && !wall_s;
        end
      end
    end
  end

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_r[i] <= home_x(i);
        seg_y_r[i] <= HOME_Y;
      end
      cube_num_r <= LEN_INIT;
    end else if (die_done_s) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_r[i] <= home_x(i);
        seg_y_r[i] <= HOME_Y;
      end
      cube_num_r <= LEN_INIT;
    end else if (move_ok_s) begin
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x_r[i] <= seg_x_r[i-1];
        seg_y_r[i] <= seg_y_r[i-1];
      end
      seg_x_r[0] <= cand_x_s;
      seg_y_r[0] <= cand_y_s;
      if (grow_s) cube_num_r <= cube_num_r + LEN_W'(1);
    end
  end

  assign query_hit   = query_hit_r;
  assign head_x      = seg_x_r[0];
  assign head_y      = seg_y_r[0];
  assign cube_num    = cube_num_r;
  assign game_status = state_r;
  assign hit_wall    = hit_wall_r;
  assign hit_body    = hit_body_r;
  assign die_flash   = die_flash_r;
  assign step        = step_r;
endmodule

// File: tb/tb_snake_engine.sv
// Directed bench: dut1 is a 40x30 die-at-wall engine, dut2 a MAX_LEN=4 wrapping engine.
module tb_snake_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1, start2, up_p, down_p, left_p, right_p, add_c;
  logic [5:0] qx;
  logic [4:0] qy;
  logic [1:0] qh1, qh2, gs1, gs2;
  logic [5:0] hx1, hx2;
  logic [4:0] hy1, hy2;
  logic [4:0] cn1;
  logic [2:0] cn2;
  logic hw1, hb1, df1, st1, hw2, hb2, df2, st2;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  snake_engine #(.TICK_DIV(4), .DIE_TICKS(2), .WRAP(0)) dut1 (
    .CLK_50M(clk), .RSTn(rst_n), .start(start1), .left_press(left_p), .right_press(right_p),
    .up_press(up_p), .down_press(down_p), .add_cube(add_c), .query_x(qx), .query_y(qy),
    .query_hit(qh1), .head_x(hx1), .head_y(hy1), .cube_num(cn1), .game_status(gs1),
    .hit_wall(hw1), .hit_body(hb1), .die_flash(df1), .step(st1));

  snake_engine #(.MAX_LEN(4), .TICK_DIV(4), .DIE_TICKS(2), .WRAP(1)) dut2 (
    .CLK_50M(clk), .RSTn(rst_n), .start(start2), .left_press(left_p), .right_press(right_p),
    .up_press(up_p), .down_press(down_p), .add_cube(add_c), .query_x(qx), .query_y(qy),
    .query_hit(qh2), .head_x(hx2), .head_y(hy2), .cube_num(cn2), .game_status(gs2),
    .hit_wall(hw2), .hit_body(hb2), .die_flash(df2), .step(st2));

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic u, d, l, r, a, s1, s2);
    up_p = u; down_p = d; left_p = l; right_p = r; add_c = a; start1 = s1; start2 = s2;
    run(1);
    up_p = 1'b0; down_p = 1'b0; left_p = 1'b0; right_p = 1'b0; add_c = 1'b0; start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic test_reset();
    #13;
    total++; if ({gs1, qh1, st1, df1, hw1, hb1} !== 8'h00) begin bad++; $display("FAIL reset_flags1: got %h want 00", {gs1, qh1, st1, df1, hw1, hb1}); end
    total++; if ({hx1, hy1, cn1} !== {6'd20, 5'd15, 5'd3}) begin bad++; $display("FAIL reset_home1: got (%0d,%0d) len %0d want (20,15) len 3", hx1, hy1, cn1); end
    total++; if ({gs2, hx2, hy2, cn2} !== {2'b00, 6'd20, 5'd15, 3'd3}) begin bad++; $display("FAIL reset_home2: got st %0d (%0d,%0d) len %0d want 0 (20,15) 3", gs2, hx2, hy2, cn2); end
    rst_n = 1'b1;
    run(1);
  endtask

  task automatic test_basic_move();
    int nsteps;
    nsteps = 0;
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      run(1);
      if (st1 === 1'b1) nsteps++;
      if (c == 3) begin
        total++; if ({hx1, st1} !== {6'd20, 1'b0}) begin bad++; $display("FAIL basic_early: got x %0d step %0d want 20 0", hx1, st1); end
      end
      if (c == 4) begin
        total++; if ({hx1, st1} !== {6'd21, 1'b1}) begin bad++; $display("FAIL basic_first: got x %0d step %0d want 21 1", hx1, st1); end
      end
    end
    total++; if (nsteps !== 3) begin bad++; $display("FAIL basic_steps: got %0d want 3", nsteps); end
    total++; if ({hx1, hy1, cn1, gs1} !== {6'd23, 5'd15, 5'd3, 2'b01}) begin bad++; $display("FAIL basic_head: got (%0d,%0d) len %0d st %0d want (23,15) 3 1", hx1, hy1, cn1, gs1); end
  endtask

  task automatic test_reversal();
    press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(2);
    total++; if ({hx1, hy1, gs1} !== {6'd23, 5'd14, 2'b01}) begin bad++; $display("FAIL reversal_head: got (%0d,%0d) st %0d want (23,14) 1", hx1, hy1, gs1); end
  endtask

  task automatic test_query();
    qx = 6'd23; qy = 5'd14; run(1);
    qx = 6'd23; qy = 5'd15;
    total++; if (qh1 !== 2'b01) begin bad++; $display("FAIL query_head: got %b want 01", qh1); end
    run(1);
    qx = 6'd21; qy = 5'd15;
    total++; if (qh1 !== 2'b10) begin bad++; $display("FAIL query_body: got %b want 10", qh1); end
    run(1);
    qx = 6'd5; qy = 5'd5;
    total++; if (qh1 !== 2'b00) begin bad++; $display("FAIL query_inactive: got %b want 00", qh1); end
    run(1);
    total++; if (qh1 !== 2'b00) begin bad++; $display("FAIL query_empty: got %b want 00", qh1); end
    total++; if ({hx1, hy1} !== {6'd23, 5'd13}) begin bad++; $display("FAIL query_align: got (%0d,%0d) want (23,13)", hx1, hy1); end
  endtask

  task automatic test_wall();
    press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(3);
    repeat (15) run(4);
    total++; if ({hx1, hy1, gs1} !== {6'd39, 5'd13, 2'b01}) begin bad++; $display("FAIL wall_edge: got (%0d,%0d) st %0d want (39,13) 1", hx1, hy1, gs1); end
    run(4);
    total++; if ({gs1, hw1, hb1, st1} !== {2'b10, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL wall_die: got st %0d wall %0d body %0d step %0d want 2 1 0 0", gs1, hw1, hb1, st1); end
    total++; if ({hx1, hy1} !== {6'd39, 5'd13}) begin bad++; $display("FAIL wall_head: got (%0d,%0d) want (39,13)", hx1, hy1); end
    run(4);
    total++; if ({gs1, df1} !== {2'b10, 1'b1}) begin bad++; $display("FAIL wall_flash: got st %0d flash %0d want 2 1", gs1, df1); end
    run(3);
    total++; if (gs1 !== 2'b10) begin bad++; $display("FAIL wall_die_len: got st %0d want 2", gs1); end
    run(1);
    total++; if ({gs1, df1, hw1, hb1} !== 5'b00000) begin bad++; $display("FAIL wall_restart: got st %0d flash %0d wall %0d body %0d want 0 0 0 0", gs1, df1, hw1, hb1); end
    total++; if ({hx1, hy1, cn1} !== {6'd20, 5'd15, 5'd3}) begin bad++; $display("FAIL wall_home: got (%0d,%0d) len %0d want (20,15) 3", hx1, hy1, cn1); end
  endtask

  task automatic test_self_hit();
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); run(3);
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); run(3);
    total++; if ({hx1, hy1, cn1} !== {6'd22, 5'd15, 5'd5}) begin bad++; $display("FAIL self_grow: got (%0d,%0d) len %0d want (22,15) 5", hx1, hy1, cn1); end
    press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); run(3);
    press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); run(3);
    press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); run(3);
    total++; if ({gs1, hb1, hw1, st1} !== {2'b10, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL self_hit: got st %0d body %0d wall %0d step %0d want 2 1 0 0", gs1, hb1, hw1, st1); end
    total++; if ({hx1, hy1, cn1} !== {6'd21, 5'd16, 5'd5}) begin bad++; $display("FAIL self_head: got (%0d,%0d) len %0d want (21,16) 5", hx1, hy1, cn1); end
    run(8);
    total++; if ({gs1, hb1} !== 3'b000) begin bad++; $display("FAIL self_restart: got st %0d body %0d want 0 0", gs1, hb1); end
  endtask

  task automatic test_tail_chase();
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); run(3);
    press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); run(3);
    press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); run(3);
    press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); run(3);
    total++; if ({gs1, st1, hx1, hy1} !== {2'b01, 1'b1, 6'd20, 5'd15}) begin bad++; $display("FAIL chase_up: got st %0d step %0d (%0d,%0d) want 1 1 (20,15)", gs1, st1, hx1, hy1); end
    press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); run(3);
    total++; if ({gs1, hx1, hy1, cn1} !== {2'b01, 6'd21, 5'd15, 5'd4}) begin bad++; $display("FAIL chase_right: got st %0d (%0d,%0d) len %0d want 1 (21,15) 4", gs1, hx1, hy1, cn1); end
    press(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); run(3);
    total++; if ({gs1, hb1, hx1, hy1} !== {2'b10, 1'b1, 6'd21, 5'd15}) begin bad++; $display("FAIL chase_grow_hit: got st %0d body %0d (%0d,%0d) want 2 1 (21,15)", gs1, hb1, hx1, hy1); end
  endtask

  task automatic test_reset_in_die();
    qx = 6'd21; qy = 5'd15;
    run(4);
    total++; if ({gs1, df1, qh1} !== {2'b10, 1'b1, 2'b01}) begin bad++; $display("FAIL die_pre: got st %0d flash %0d q %b want 2 1 01", gs1, df1, qh1); end
    rst_n = 1'b0;
    #2;
    total++; if ({gs1, qh1, st1, df1, hw1, hb1} !== 8'h00) begin bad++; $display("FAIL die_reset_flags: got %h want 00", {gs1, qh1, st1, df1, hw1, hb1}); end
    total++; if ({hx1, hy1, cn1} !== {6'd20, 5'd15, 5'd3}) begin bad++; $display("FAIL die_reset_home: got (%0d,%0d) len %0d want (20,15) 3", hx1, hy1, cn1); end
    rst_n = 1'b1;
    run(1);
  endtask

  task automatic test_growth_cap_wrap();
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); run(3);
    total++; if ({cn2, hx2} !== {3'd4, 6'd21}) begin bad++; $display("FAIL cap_grow: got len %0d x %0d want 4 21", cn2, hx2); end
    qx = 6'd18; qy = 5'd15; run(1);
    total++; if (qh2 !== 2'b10) begin bad++; $display("FAIL cap_tail_kept: got %b want 10", qh2); end
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); run(2);
    total++; if ({cn2, hx2} !== {3'd4, 6'd22}) begin bad++; $display("FAIL cap_hold1: got len %0d x %0d want 4 22", cn2, hx2); end
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); run(3);
    total++; if ({cn2, hx2} !== {3'd4, 6'd23}) begin bad++; $display("FAIL cap_hold2: got len %0d x %0d want 4 23", cn2, hx2); end
    qx = 6'd19; qy = 5'd15; run(1);
    total++; if (qh2 !== 2'b00) begin bad++; $display("FAIL cap_dropped: got %b want 00", qh2); end
    run(3);
    repeat (15) run(4);
    total++; if ({hx2, hy2} !== {6'd39, 5'd15}) begin bad++; $display("FAIL wrap_edge: got (%0d,%0d) want (39,15)", hx2, hy2); end
    run(4);
    total++; if ({gs2, st2, hw2, hx2, hy2} !== {2'b01, 1'b1, 1'b0, 6'd0, 5'd15}) begin bad++; $display("FAIL wrap_head: got st %0d step %0d wall %0d (%0d,%0d) want 1 1 0 (0,15)", gs2, st2, hw2, hx2, hy2); end
  endtask

  initial begin
    start1 = 1'b0; start2 = 1'b0; up_p = 1'b0; down_p = 1'b0;
    left_p = 1'b0; right_p = 1'b0; add_c = 1'b0; qx = 6'd0; qy = 5'd0;
    test_reset();
    test_basic_move();
    test_reversal();
    test_query();
    test_wall();
    test_self_hit();
    test_tail_chase();
    test_reset_in_die();
    test_growth_cap_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
